mag_sequencer: RTL

MAG_SEQUENCER -- requirements
Module: mag_sequencer

---
 rtl/mag_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mag_sequencer.sv
// Purpose : microwave magnetron sequencer; load/start/pause/cancel cook timer, drive external SR latch.
// Latency : every output is a flop; it reflects the inputs sampled at the previous clk edge.
// Backpr. : none; single-cycle request pulses are consumed or ignored in the cycle they arrive.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   start/stop/clear       one-cycle operator requests (stop beats start)
//   door_closed            door interlock level, 1 = shut
//   sec_tick               one-cycle pulse per second
//   time_load, time_in     load a cook time in seconds
//   latch_S, latch_R       one-cycle set/reset pulses to the external magnetron latch
//   mag_on                 high exactly while state == COOKING
//   time_left              remaining seconds
//   state                  IDLE=0 READY=1 COOKING=2 PAUSED=3 DONE=4
//   done_beep              high while in DONE
module mag_sequencer #(
  parameter int DONE_BEEP_SEC = 3,
  parameter int TW            = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          door_closed,
  input  logic          sec_tick,
  input  logic          time_load,
  input  logic [TW-1:0] time_in,
  output logic          latch_S,
  output logic          latch_R,
  output logic          mag_on,
  output logic [TW-1:0] time_left,
  output logic [2:0]    state,
  output logic          done_beep
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    READY   = 3'b001,
    COOKING = 3'b010,
    PAUSED  = 3'b011,
    DONE    = 3'b100
  } state_t;

  // Counter holds 0..DONE_BEEP_SEC-1 while beeping; sized to hold DONE_BEEP_SEC itself.
  localparam int CW = (DONE_BEEP_SEC > 1) ? $clog2(DONE_BEEP_SEC + 1) : 1;
  localparam logic [CW-1:0] BEEP_LAST = CW'(DONE_BEEP_SEC - 1);

  logic [CW-1:0] beep_cnt;
  state_t        nxt_state;
  logic [TW-1:0] nxt_time;
  logic [CW-1:0] nxt_cnt;

  always_comb begin
    nxt_state = IDLE;
    nxt_time  = time_left;
    nxt_cnt   = '0;          // any state other than DONE keeps the counter cleared
    case (state)
      IDLE: begin
        nxt_state = IDLE;
        if (time_load && (time_in != '0)) begin
          nxt_state = READY;
          nxt_time  = time_in;
        end
      end
      READY: begin
        nxt_state = READY;
        if (clear) begin
          nxt_state = IDLE;
          nxt_time  = '0;
        end else if (time_load) begin
          nxt_time  = time_in;
          nxt_state = (time_in == '0) ? IDLE : READY;
        end else if (start && !stop && door_closed) begin
          nxt_state = COOKING;
        end
      end
      COOKING: begin
        nxt_state = COOKING;
        // Door/stop win over the tick, so a pausing tick never eats a second.
        if (!door_closed || stop) begin
          nxt_state = PAUSED;
        end else if (sec_tick) begin
          if (time_left == TW'(1)) begin
            nxt_state = DONE;
            nxt_time  = '0;
          end else begin
            nxt_time = time_left - TW'(1);
          end
        end
      end
      PAUSED: begin
        nxt_state = PAUSED;
        if (stop || clear) begin
          nxt_state = IDLE;
          nxt_time  = '0;
        end else if (start && door_closed) begin
          nxt_state = COOKING;
        end
      end
      DONE: begin
        nxt_state = DONE;
        nxt_cnt   = beep_cnt;
        if (stop || clear) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else if (sec_tick) begin
          if (beep_cnt == BEEP_LAST) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = beep_cnt + CW'(1);
          end
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_time  = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      time_left <= '0;
      beep_cnt  <= '0;
      mag_on    <= 1'b0;
      latch_S   <= 1'b0;
      latch_R   <= 1'b1;   // hold the external latch off through reset
      done_beep <= 1'b0;
    end else begin
      state     <= nxt_state;
      time_left <= nxt_time;
      beep_cnt  <= nxt_cnt;
      mag_on    <= (nxt_state == COOKING);
      latch_S   <= (nxt_state == COOKING) && (state != COOKING);
      latch_R   <= (state == COOKING) && (nxt_state != COOKING);
      done_beep <= (nxt_state == DONE);
    end
  end

endmodule
